// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch initiator for the pipelined MIPS core.
// Issues imem reads, absorbs ID stalls in a 2-entry skid buffer and applies redirects.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   stall                       IF/ID hold from hazard unit
//   redirect_valid/redirect_pc  branch/jump taken and its target
//   imem_memread/imem_address   read request to instruction memory
//   imem_readdata               read data, one cycle after the request
//   if_valid/if_instr/if_pc     instruction bundle to IF/ID
//   if_pc_plus4                 if_pc + 4
//   misalign_err                sticky, set by a misaligned redirect target
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_memread,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_readdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        misalign_err
);

    logic [31:0] pc;
    logic        inflight;
    logic [31:0] inf_pc;
    logic        inf_epoch;
    logic        epoch;

    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc    [2];
    logic        head;
    logic [1:0]  buf_count;

    logic [2:0]  occupancy;
    logic        req;
    logic        rsp_live;
    logic        accept;
    logic        pop;
    logic        push;
    logic        tail;

    // Buffer plus in-flight slot never exceeds two, so the buffer cannot overflow.
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight};
    assign req = rst_n & ~redirect_valid & (occupancy < 3'd2);

    assign imem_memread = req;
    assign imem_address = rst_n ? pc : RESET_PC;

    // Responses from before the latest redirect carry a stale epoch.
    assign rsp_live = inflight & (inf_epoch == epoch);
    assign accept   = ~stall | ~if_valid;
    assign pop      = accept & (buf_count != 2'd0);
    assign push     = rsp_live & ~(accept & (buf_count == 2'd0));
    assign tail     = head ^ buf_count[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            inflight     <= 1'b0;
            inf_pc       <= RESET_PC;
            inf_epoch    <= 1'b0;
            epoch        <= 1'b0;
            head         <= 1'b0;
            buf_count    <= 2'd0;
            if_valid     <= 1'b0;
            if_instr     <= NOP_WORD;
            if_pc        <= 32'd0;
            if_pc_plus4  <= 32'd0;
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            pc        <= {redirect_pc[31:2], 2'b00};
            epoch     <= ~epoch;
            inflight  <= 1'b0;
            head      <= 1'b0;
            buf_count <= 2'd0;
            if_valid  <= 1'b0;
            if_instr  <= NOP_WORD;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else begin
            inflight <= req;
            if (req) begin
                pc        <= pc + PC_STEP;
                inf_pc    <= pc;
                inf_epoch <= epoch;
            end

            if (push) begin
                buf_instr[tail] <= imem_readdata;
                buf_pc[tail]    <= inf_pc;
            end
            if (pop) begin
                head <= ~head;
            end
            unique case ({push, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: ;
            endcase

            if (accept) begin
                unique case (1'b1)
                    (buf_count != 2'd0): begin
                        if_valid    <= 1'b1;
                        if_instr    <= buf_instr[head];
                        if_pc       <= buf_pc[head];
                        if_pc_plus4 <= buf_pc[head] + 32'd4;
                    end
                    (buf_count == 2'd0) && rsp_live: begin
                        if_valid    <= 1'b1;
                        if_instr    <= imem_readdata;
                        if_pc       <= inf_pc;
                        if_pc_plus4 <= inf_pc + 32'd4;
                    end
                    default: begin
                        if_valid <= 1'b0;
                        if_instr <= NOP_WORD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: self-checking bench for if_fetch_unit.
// Scoreboard of requested PCs checked against the instruction stream.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_memread;
    logic [31:0] imem_address;
    logic [31:0] imem_readdata = 32'd0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        misalign_err;

    int checks = 0;
    int failures = 0;
    int popped = 0;

    logic [31:0] exp_q [$];
    logic [31:0] exp_req = 32'd0;
    logic [31:0] e;

    if_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_memread   (imem_memread),
        .imem_address   (imem_address),
        .imem_readdata  (imem_readdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h8C81_0004;
            32'h04:  return 32'h0065_3022;
            32'h08:  return 32'h00E6_4026;
            32'h0C:  return 32'h3549_0016;
            32'h10:  return 32'h3549_0016;
            default: return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (imem_memread === 1'b1) begin
            imem_readdata <= mem_word(imem_address);
        end
    end

    // Scoreboard: push each request's expected PC, pop on each consumed output.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_req = 32'd0;
            checks++;
            if (imem_memread !== 1'b0) begin
                failures++;
                $display("FAIL sb_rst_memread got=%b exp=0", imem_memread);
            end
        end else if (redirect_valid) begin
            exp_q.delete();
            exp_req = {redirect_pc[31:2], 2'b00};
            checks++;
            if (imem_memread !== 1'b0) begin
                failures++;
                $display("FAIL sb_redir_memread got=%b exp=0", imem_memread);
            end
        end else begin
            if (if_valid === 1'b1 && !stall) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_extra got_pc=%h exp=none", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    if (if_pc !== e || if_instr !== mem_word(e) ||
                        if_pc_plus4 !== e + 32'd4) begin
                        failures++;
                        $display("FAIL sb_out got=%h/%h/%h exp=%h/%h/%h",
                                 if_pc, if_instr, if_pc_plus4,
                                 e, mem_word(e), e + 32'd4);
                    end
                end
            end
            if (imem_memread === 1'b1) begin
                checks++;
                if (imem_address !== exp_req) begin
                    failures++;
                    $display("FAIL sb_addr got=%h exp=%h", imem_address, exp_req);
                end
                exp_q.push_back(exp_req);
                exp_req = exp_req + 32'd4;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        step(2);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", if_valid);
        end
        checks++;
        if (if_instr !== 32'd0) begin
            failures++;
            $display("FAIL reset_instr got=%h exp=0", if_instr);
        end
        checks++;
        if (if_pc !== 32'd0 || if_pc_plus4 !== 32'd0) begin
            failures++;
            $display("FAIL reset_pc got=%h/%h exp=0/0", if_pc, if_pc_plus4);
        end
        checks++;
        if (misalign_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_misalign got=%b exp=0", misalign_err);
        end
        checks++;
        if (imem_memread !== 1'b0 || imem_address !== 32'd0) begin
            failures++;
            $display("FAIL reset_req got=%b/%h exp=0/0", imem_memread, imem_address);
        end
    endtask

    task automatic test_sequential();
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_memread !== 1'b1 || imem_address !== 32'd0) begin
            failures++;
            $display("FAIL seq_first_req got=%b/%h exp=1/0", imem_memread, imem_address);
        end
        step();
        checks++;
        if (imem_address !== 32'd4 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL seq_second got=%h/%b exp=4/0", imem_address, if_valid);
        end
        step();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) ||
                if_instr !== mem_word(32'(4 * i)) ||
                if_pc_plus4 !== 32'(4 * i + 4)) begin
                failures++;
                $display("FAIL seq_out got=%b/%h/%h exp=1/%h/%h",
                         if_valid, if_pc, if_instr, 4 * i, mem_word(32'(4 * i)));
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        logic [31:0] exp;
        held = if_pc;
        stall = 1'b1;
        #1;
        checks++;
        if (imem_memread !== 1'b1 || if_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_start got=%b/%b exp=1/1", imem_memread, if_valid);
        end
        for (int k = 1; k < 5; k++) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== held || imem_memread !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold got=%b/%h/%b exp=1/%h/0",
                         if_valid, if_pc, imem_memread, held);
            end
        end
        step();
        stall = 1'b0;
        exp = held;
        for (int j = 0; j < 7; j++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== exp) begin
                failures++;
                $display("FAIL stall_drain got=%b/%h exp=1/%h", if_valid, if_pc, exp);
            end
            exp = exp + 32'd4;
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step(3);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
            failures++;
            $display("FAIL redir_pre got=%b/%h exp=1/4", if_valid, if_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        #1;
        checks++;
        if (imem_memread !== 1'b0) begin
            failures++;
            $display("FAIL redir_noreq got=%b exp=0", imem_memread);
        end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_memread !== 1'b1 || imem_address !== 32'h10) begin
            failures++;
            $display("FAIL redir_target_req got=%b/%b/%h exp=0/1/10",
                     if_valid, imem_memread, imem_address);
        end
        step();
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_gap got=%b exp=0", if_valid);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== 32'h3549_0016) begin
            failures++;
            $display("FAIL redir_target got=%b/%h/%h exp=1/10/35490016",
                     if_valid, if_pc, if_instr);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h14) begin
            failures++;
            $display("FAIL redir_next got=%b/%h exp=1/14", if_valid, if_pc);
        end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        step(3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_address !== 32'h40) begin
            failures++;
            $display("FAIL rstall_flush got=%b/%h exp=0/40", if_valid, imem_address);
        end
        step();
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstall_gap got=%b exp=0", if_valid);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40) begin
            failures++;
            $display("FAIL rstall_target got=%b/%h exp=1/40", if_valid, if_pc);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h44) begin
            failures++;
            $display("FAIL rstall_next got=%b/%h exp=1/44", if_valid, if_pc);
        end
    endtask

    task automatic test_misalign();
        checks++;
        if (misalign_err !== 1'b0) begin
            failures++;
            $display("FAIL mis_pre got=%b exp=0", misalign_err);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0E;
        step();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (misalign_err !== 1'b1 || imem_address !== 32'h0C) begin
            failures++;
            $display("FAIL mis_set got=%b/%h exp=1/0c", misalign_err, imem_address);
        end
        step(2);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0C || if_instr !== 32'h3549_0016) begin
            failures++;
            $display("FAIL mis_fetch got=%b/%h/%h exp=1/0c/35490016",
                     if_valid, if_pc, if_instr);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        step(2);
        checks++;
        if (misalign_err !== 1'b1 || if_pc !== 32'h20) begin
            failures++;
            $display("FAIL mis_sticky got=%b/%h exp=1/20", misalign_err, if_pc);
        end
        step();
    endtask

    task automatic test_midreset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_memread !== 1'b0 || imem_address !== 32'd0) begin
            failures++;
            $display("FAIL mrst_req got=%b/%h exp=0/0", imem_memread, imem_address);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0 || misalign_err !== 1'b0) begin
            failures++;
            $display("FAIL mrst_clear got=%b/%b exp=0/0", if_valid, misalign_err);
        end
        checks++;
        if (imem_memread !== 1'b1 || imem_address !== 32'd0) begin
            failures++;
            $display("FAIL mrst_first got=%b/%h exp=1/0", imem_memread, imem_address);
        end
        step();
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL mrst_discard got=%b exp=0", if_valid);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== 32'h8C81_0004) begin
            failures++;
            $display("FAIL mrst_resume got=%b/%h/%h exp=1/0/8c810004",
                     if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        step(2);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFF8) begin
            failures++;
            $display("FAIL wrap_f8 got=%b/%h exp=1/fffffff8", if_valid, if_pc);
        end
        step();
        checks++;
        if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'd0) begin
            failures++;
            $display("FAIL wrap_fc got=%h/%h exp=fffffffc/0", if_pc, if_pc_plus4);
        end
        step();
        checks++;
        if (if_pc !== 32'd0 || if_instr !== 32'h8C81_0004 || if_pc_plus4 !== 32'd4) begin
            failures++;
            $display("FAIL wrap_zero got=%h/%h/%h exp=0/8c810004/4",
                     if_pc, if_instr, if_pc_plus4);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = popped;
        for (int c = 0; c < 12; c++) begin
            stall = c[0];
            step();
        end
        stall = 1'b0;
        step(4);
        checks++;
        if (popped - start < 5) begin
            failures++;
            $display("FAIL b2b_throughput got=%0d exp>=5", popped - start);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_misalign();
        test_midreset();
        test_wrap();
        test_back_to_back();
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
